// File: rtl/finish_controller.sv
// rtl/finish_controller.sv - end-of-simulation arbiter with drain delay and heartbeat watchdog
module finish_controller #(
    parameter int NUM_REQ        = 4,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] end_req,
    input  logic [NUM_REQ-1:0] end_fail,
    input  logic               heartbeat,
    output logic [NUM_REQ-1:0] end_ack,
    output logic [WIN_W-1:0]   winner,
    output logic [1:0]         exit_code,
    output logic               finish,
    output logic               done
);

    localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    localparam logic [1:0] CODE_PASS    = 2'b00;
    localparam logic [1:0] CODE_FAIL    = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {RUN, DRAIN, FINISH, DONE} state_t;

    state_t             state_q, state_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [7:0]         drain_q, drain_d;
    logic [NUM_REQ-1:0] ack_d;
    logic [WIN_W-1:0]   winner_d;
    logic [1:0]         code_d;
    logic               finish_d;
    logic               done_d;

    logic [NUM_REQ-1:0] grant_onehot;
    logic [WIN_W-1:0]   grant_idx;
    logic               any_fail;
    logic               timeout_hit;
    logic               enter_end;

    // Lowest-index requester wins; scanning downward leaves the lowest set bit last.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (end_req[i]) begin
                grant_onehot = NUM_REQ'(1) << i;
                grant_idx    = WIN_W'(i);
            end
        end
    end

    assign any_fail    = |(end_req & end_fail);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !heartbeat && (wd_q >= WD_LAST);

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        drain_d   = drain_q;
        ack_d     = '0;
        winner_d  = winner;
        code_d    = exit_code;
        finish_d  = 1'b0;
        done_d    = done;
        enter_end = 1'b0;

        case (state_q)
            RUN: begin
                if (|end_req) begin
                    ack_d     = grant_onehot;
                    winner_d  = grant_idx;
                    code_d    = any_fail ? CODE_FAIL : CODE_PASS;
                    enter_end = 1'b1;
                end else if (timeout_hit) begin
                    winner_d  = '0;
                    code_d    = CODE_TIMEOUT;
                    enter_end = 1'b1;
                end else if (heartbeat) begin
                    wd_d = '0;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end

                if (enter_end) begin
                    drain_d = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d  = FINISH;
                        finish_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // A late failure can only turn a pass into a fail; timeouts stay timeouts.
                if (exit_code == CODE_PASS && any_fail) begin
                    code_d = CODE_FAIL;
                end
                if (drain_q == DRAIN_LAST) begin
                    state_d  = FINISH;
                    finish_d = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wd_q      <= '0;
            drain_q   <= '0;
            end_ack   <= '0;
            winner    <= '0;
            exit_code <= CODE_PASS;
            finish    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            drain_q   <= drain_d;
            end_ack   <= ack_d;
            winner    <= winner_d;
            exit_code <= code_d;
            finish    <= finish_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_finish_controller.sv
// tb/tb_finish_controller.sv - self-checking bench for finish_controller (drain 4 / drain 0 builds)
module tb_finish_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] fail;
    logic       hb;

    logic [3:0] a_ack, b_ack;
    logic [1:0] a_win, b_win;
    logic [1:0] a_code, b_code;
    logic       a_fin, b_fin;
    logic       a_done, b_done;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    finish_controller #(.NUM_REQ(4), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .reset(rst), .end_req(req), .end_fail(fail), .heartbeat(hb),
        .end_ack(a_ack), .winner(a_win), .exit_code(a_code), .finish(a_fin), .done(a_done)
    );

    finish_controller #(.NUM_REQ(4), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(rst), .end_req(req), .end_fail(fail), .heartbeat(hb),
        .end_ack(b_ack), .winner(b_win), .exit_code(b_code), .finish(b_fin), .done(b_done)
    );

    // Model: outcome latched at the decision edge, everything else is "cycles since decision".
    typedef struct packed {
        logic       granted;
        logic [3:0] ack;
        logic [1:0] win;
        logic [1:0] code;
        int         since;
        int         silent;
    } model_t;

    model_t ma, mb;

    function automatic model_t step(model_t m, logic r, logic [3:0] q, logic [3:0] f,
                                   logic h, int d, int to);
        model_t n;
        int     idx;
        n   = m;
        idx = 0;
        if (r) begin
            n = '0;
        end else begin
            n.ack = 4'b0;
            if (!m.granted) begin
                if (q != 4'b0) begin
                    for (int i = 3; i >= 0; i--) if (q[i]) idx = i;
                    n.granted = 1'b1;
                    n.since   = 0;
                    n.ack     = 4'b1 << idx;
                    n.win     = idx[1:0];
                    n.code    = ((q & f) != 4'b0) ? 2'd1 : 2'd0;
                end else if (!h && to != 0 && m.silent + 1 >= to) begin
                    n.granted = 1'b1;
                    n.since   = 0;
                    n.win     = 2'd0;
                    n.code    = 2'd2;
                end else begin
                    n.silent = h ? 0 : m.silent + 1;
                end
            end else begin
                if (m.since < d && m.code == 2'd0 && (q & f) != 4'b0) n.code = 2'd1;
                n.since = m.since + 1;
            end
        end
        return n;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        ma <= step(ma, rst, req, fail, hb, 4, 8);
        mb <= step(mb, rst, req, fail, hb, 0, 0);
    end

    always @(negedge clk) begin
        if (started) begin
            check("a_ack",  a_ack,  ma.ack);
            check("a_win",  a_win,  ma.win);
            check("a_code", a_code, ma.code);
            check("a_fin",  a_fin,  ma.granted && ma.since == 4);
            check("a_done", a_done, ma.granted && ma.since > 4);
            check("b_ack",  b_ack,  mb.ack);
            check("b_win",  b_win,  mb.win);
            check("b_code", b_code, mb.code);
            check("b_fin",  b_fin,  mb.granted && mb.since == 0);
            check("b_done", b_done, mb.granted && mb.since > 0);
        end
    end

    initial begin
        rst = 1'b1; req = 4'b0; fail = 4'b0; hb = 1'b1;
        tick(2);
        started = 1'b1;
        check("rst_ack", a_ack, 4'b0);
        check("rst_code", a_code, 2'b00);
        check("rst_done", a_done, 1'b0);

        // single pass request
        rst = 1'b0; tick;
        req = 4'b0100; tick; req = 4'b0;
        check("s1_ack", a_ack, 4'b0100);
        check("s1_win", a_win, 2);
        check("s1_code", a_code, 2'b00);
        check("s1_fin_t", a_fin, 1'b0);
        check("s1_b_fin_t", b_fin, 1'b1);
        tick(3);
        check("s1_fin_t3", a_fin, 1'b0);
        tick;
        check("s1_fin_t4", a_fin, 1'b1);
        tick;
        check("s1_done_t5", a_done, 1'b1);
        check("s1_fin_t5", a_fin, 1'b0);
        rst = 1'b1; tick; rst = 1'b0;

        // lowest index wins, fail from a non-granted requester still counts
        req = 4'b1010; fail = 4'b1000; tick; req = 4'b0; fail = 4'b0;
        check("s2_ack", a_ack, 4'b0010);
        check("s2_win", a_win, 1);
        check("s2_code", a_code, 2'b01);
        check("s2_b_code", b_code, 2'b01);
        tick(6); rst = 1'b1; tick; rst = 1'b0;

        // fail arriving during drain upgrades a pass
        req = 4'b0001; tick;
        fail = 4'b0001; tick; req = 4'b0; fail = 4'b0;
        check("s3_code", a_code, 2'b01);
        check("s3_ack", a_ack, 4'b0);
        check("s3_b_code", b_code, 2'b00);
        check("s3_b_done", b_done, 1'b1);
        tick(6); rst = 1'b1; tick; rst = 1'b0;

        // watchdog timeout after 8 silent edges, code immune to later fails
        hb = 1'b0; tick(7);
        check("s4_code_7", a_code, 2'b00);
        check("s4_fin_7", a_fin, 1'b0);
        tick;
        check("s4_code_8", a_code, 2'b10);
        check("s4_ack_8", a_ack, 4'b0);
        check("s4_win_8", a_win, 0);
        req = 4'b0001; fail = 4'b0001; tick; req = 4'b0; fail = 4'b0;
        check("s4_code_keep", a_code, 2'b10);
        tick(3);
        check("s4_fin", a_fin, 1'b1);
        hb = 1'b1; rst = 1'b1; tick; rst = 1'b0;

        // heartbeat on edge 7 restarts the count
        hb = 1'b0; tick(6);
        hb = 1'b1; tick;
        hb = 1'b0; tick(7);
        check("s5_code_no_to", a_code, 2'b00);
        check("s5_fin_no_to", a_fin, 1'b0);
        tick;
        check("s5_code_to", a_code, 2'b10);
        hb = 1'b1; rst = 1'b1; tick; rst = 1'b0;

        // reset mid-drain suppresses finish, then re-arm
        req = 4'b0100; tick; req = 4'b0;
        tick(2);
        rst = 1'b1; tick;
        check("s6_ack", a_ack, 4'b0);
        check("s6_win", a_win, 0);
        check("s6_code", a_code, 2'b00);
        check("s6_fin", a_fin, 1'b0);
        check("s6_done", a_done, 1'b0);
        rst = 1'b0; tick(4);
        check("s6_no_fin", a_fin, 1'b0);
        req = 4'b1000; tick; req = 4'b0;
        check("s6_ack2", a_ack, 4'b1000);
        check("s6_win2", a_win, 3);
        tick(6); rst = 1'b1; tick; rst = 1'b0;

        // zero drain: ack and finish together
        req = 4'b0001; tick; req = 4'b0;
        check("s7_b_ack", b_ack, 4'b0001);
        check("s7_b_fin", b_fin, 1'b1);
        check("s7_b_done", b_done, 1'b0);
        tick;
        check("s7_b_done1", b_done, 1'b1);
        check("s7_b_fin1", b_fin, 1'b0);
        rst = 1'b1; tick; rst = 1'b0;

        // request on the timeout edge beats the timeout
        hb = 1'b0; tick(7);
        req = 4'b0010; tick; req = 4'b0;
        check("s8_ack", a_ack, 4'b0010);
        check("s8_code", a_code, 2'b00);
        check("s8_win", a_win, 1);
        hb = 1'b1; tick(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
